cache_bank_nway: RTL
====================

Name: cache_bank_nway

Overview:
- Parametrised N-way set-associative cache bank with its own tag/valid storage, hit detection, victim selection and line-refill sequencing.
- Accepts one request at a time over a valid/ready handshake and returns a single-cycle response pulse.
- On a read miss, fetches the full line from main memory over a request/beat interface.
- Sits between the core-side cache controller and the main-memory port; write policy is write-through, no-write-allocate (the memory write path is outside this block).

Parameters:
- NUM_WAYS, 4, associativity; power of two, >= 2; WAY_W = clog2(NUM_WAYS).
- TAG_W, 20, tag width in bits.
- INDEX_W, 6, set index width; sets = 2^INDEX_W.
- OFFSET_W, 2, word offset width; words per line = 2^OFFSET_W.
- DATA_W, 32, word width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_tag  in  TAG_W  request tag.
- req_index  in  INDEX_W  request set.
- req_offset  in  OFFSET_W  word within line.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  request hit an existing line.
- rsp_way  out  WAY_W  way hit or filled.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- mem_req_valid  out  1  line fetch request.
- mem_req_ready  in  1  memory accepts the fetch.
- mem_req_tag  out  TAG_W  fetch tag.
- mem_req_index  out  INDEX_W  fetch set.
- mem_rsp_valid  in  1  refill beat valid.
- mem_rsp_data  in  DATA_W  refill word; beats arrive in offset order 0..2^OFFSET_W-1.
- flush  in  1  invalidate all lines.

Behaviour:
- Reset (async): state IDLE; all valid bits 0; all per-set victim pointers 0; all outputs 0. Data and tag arrays are not cleared.
- Reset mid-refill: refill is aborted. The partially filled line stays invalid, and the in-flight memory beats are ignored after reset deasserts.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
- IDLE:
  - req_ready = 1 unless flush = 1.
  - flush = 1: clears every valid bit that cycle, state stays IDLE, no request accepted (flush wins over a simultaneous req_valid).
  - req_valid & req_ready: register we/tag/index/offset/wdata, go to LOOKUP.
- LOOKUP (one cycle after accept): hit = valid & tag match for any way; the lowest way index wins if more than one matches.
  - Read hit: rsp_valid = 1, rsp_hit = 1, rsp_way = hit way, rsp_rdata = stored word → IDLE. Accept-to-response latency is 1 cycle.
  - Write hit: word written into the hit way at the clock edge; rsp_valid = 1, rsp_hit = 1, rsp_rdata = 0 → IDLE.
  - Write miss: no allocation; rsp_valid = 1, rsp_hit = 0, rsp_way = 0 → IDLE.
  - Read miss: latch victim → MISS_REQ. Victim = lowest-index invalid way in the set; if all ways are valid, the set's victim pointer.
- MISS_REQ:
  - mem_req_valid = 1 with the registered tag/index, held stable until mem_req_ready = 1 is sampled.
  - Then clear the victim's valid bit, reset the beat counter to 0 → REFILL.
- REFILL:
  - Each mem_rsp_valid beat writes mem_rsp_data into the victim way at word = beat counter, then increments the counter. mem_rsp_valid in any other state is ignored.
  - Beat 2^OFFSET_W-1: write victim tag, set valid. If the victim was the pointer choice, the pointer advances to (victim+1) mod NUM_WAYS with wrap-around; an invalid-way fill leaves the pointer unchanged → RESPOND.
- RESPOND: rsp_valid = 1, rsp_hit = 0, rsp_way = victim, rsp_rdata = filled word at the requested offset → IDLE.
- flush outside IDLE: ignored; the requester holds flush until req_ready = 1.
- rsp_valid is high for exactly one cycle per accepted request; req_ready = 0 in every state except IDLE.

Test Plan:
1. Reset, then read tag 0x00012 / index 5 / offset 2 → miss; mem_req_valid with tag 0x00012 / index 5. Refill beats 0xA0..0xA3 → RESPOND: rsp_hit = 0, rsp_way = 0, rsp_rdata = 0xA2.
2. Same read again → rsp_valid exactly 1 cycle after accept, rsp_hit = 1, rsp_way = 0, rsp_rdata = 0xA2. Write 0xDEADBEEF to offset 2, then read → 0xDEADBEEF, hit.
3. Five distinct tags into index 5 (NUM_WAYS = 4): fills go to ways 0, 1, 2, 3, then the 5th evicts way 0 (pointer wraps). A re-read of the first tag misses.
4. Write to an uncached address → rsp_hit = 0, mem_req_valid never asserted; a subsequent read of that address still misses.
5. Assert flush together with req_valid in IDLE → req_ready = 0; all valid bits cleared. A read of the tag from test 2 then misses.
6. Assert reset after 2 refill beats → outputs 0, state IDLE. Leftover mem_rsp_valid beats are ignored; a read of the same address misses and refetches.

Source files
------------

// File: rtl/cache_bank_nway.sv
// N-way set-associative cache bank: tag/valid storage, hit detection, victim
// selection (lowest invalid way, else per-set round-robin pointer) and line refill.
module cache_bank_nway #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 20,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32,
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [INDEX_W-1:0]  req_index,
    input  logic [OFFSET_W-1:0] req_offset,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic                rsp_hit,
    output logic [WAY_W-1:0]    rsp_way,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [TAG_W-1:0]    mem_req_tag,
    output logic [INDEX_W-1:0]  mem_req_index,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                flush
);
    localparam int SETS   = 1 << INDEX_W;
    localparam int ADDR_W = WAY_W + INDEX_W + OFFSET_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND} state_t;

    state_t                state_reg;
    logic                  ready_reg;
    logic                  we_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic [INDEX_W-1:0]    index_reg;
    logic [OFFSET_W-1:0]   offset_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [WAY_W-1:0]      victim_reg;
    logic                  use_ptr_reg;
    logic [OFFSET_W-1:0]   beat_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_hit_reg;
    logic [WAY_W-1:0]      rsp_way_reg;
    logic [DATA_W-1:0]     rsp_rdata_reg;
    logic                  mem_req_valid_reg;

    logic [NUM_WAYS-1:0]   valid_reg [SETS];
    logic [WAY_W-1:0]      ptr_reg   [SETS];
    logic [TAG_W-1:0]      tag_mem   [SETS*NUM_WAYS];
    logic [DATA_W-1:0]     data_mem  [2**ADDR_W];

    logic [NUM_WAYS-1:0]   set_valid;
    logic [NUM_WAYS-1:0]   hit_vec;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  free_any;
    logic [WAY_W-1:0]      free_way;
    logic                  data_we;
    logic [ADDR_W-1:0]     data_waddr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  last_beat;

    assign set_valid = valid_reg[index_reg];
    assign last_beat = (beat_reg == '1);

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_cmp
            assign hit_vec[gi] = set_valid[gi] &&
                                 (tag_mem[{index_reg, WAY_W'(gi)}] == tag_reg);
        end
    endgenerate

    // Scan downwards so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!set_valid[i]) begin
                free_any = 1'b1;
                free_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        data_we    = 1'b0;
        data_waddr = '0;
        data_wdata = '0;
        if (state_reg == LOOKUP && we_reg && hit) begin
            data_we    = 1'b1;
            data_waddr = {hit_way, index_reg, offset_reg};
            data_wdata = wdata_reg;
        end else if (state_reg == REFILL && mem_rsp_valid) begin
            data_we    = 1'b1;
            data_waddr = {victim_reg, index_reg, beat_reg};
            data_wdata = mem_rsp_data;
        end
    end

    // Storage arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (data_we)
            data_mem[data_waddr] <= data_wdata;
        if (state_reg == REFILL && mem_rsp_valid && last_beat)
            tag_mem[{index_reg, victim_reg}] <= tag_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            ready_reg         <= 1'b0;
            we_reg            <= 1'b0;
            tag_reg           <= '0;
            index_reg         <= '0;
            offset_reg        <= '0;
            wdata_reg         <= '0;
            victim_reg        <= '0;
            use_ptr_reg       <= 1'b0;
            beat_reg          <= '0;
            rsp_valid_reg     <= 1'b0;
            rsp_hit_reg       <= 1'b0;
            rsp_way_reg       <= '0;
            rsp_rdata_reg     <= '0;
            mem_req_valid_reg <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                ptr_reg[s]   <= '0;
            end
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++)
                            valid_reg[s] <= '0;
                        ready_reg <= 1'b1;
                    end else if (req_valid && ready_reg) begin
                        we_reg     <= req_we;
                        tag_reg    <= req_tag;
                        index_reg  <= req_index;
                        offset_reg <= req_offset;
                        wdata_reg  <= req_wdata;
                        ready_reg  <= 1'b0;
                        state_reg  <= LOOKUP;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit || we_reg) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_hit_reg   <= hit;
                        rsp_way_reg   <= hit ? hit_way : '0;
                        rsp_rdata_reg <= (hit && !we_reg) ?
                                         data_mem[{hit_way, index_reg, offset_reg}] : '0;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        victim_reg        <= free_any ? free_way : ptr_reg[index_reg];
                        use_ptr_reg       <= !free_any;
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_reg                <= 1'b0;
                        valid_reg[index_reg][victim_reg] <= 1'b0;
                        beat_reg                         <= '0;
                        state_reg                        <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rsp_valid) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == offset_reg)
                            rsp_rdata_reg <= mem_rsp_data;
                        if (last_beat) begin
                            valid_reg[index_reg][victim_reg] <= 1'b1;
                            if (use_ptr_reg)
                                ptr_reg[index_reg] <= victim_reg + WAY_W'(1);
                            rsp_valid_reg <= 1'b1;
                            rsp_hit_reg   <= 1'b0;
                            rsp_way_reg   <= victim_reg;
                            state_reg     <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready     = ready_reg && !flush && (state_reg == IDLE);
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_hit       = rsp_hit_reg;
    assign rsp_way       = rsp_way_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_tag   = tag_reg;
    assign mem_req_index = index_reg;
endmodule
